// File: rtl/tisc_pkg.sv
// tisc_pkg: types shared by the TISC control unit, datapath and ALU.
//   opcode_e  : instruction opcodes (4-bit encoding, zero-extended when the
//               opcode field is wider)
//   state_e   : multi-cycle control unit states
//   alu_op_e  : ALU operation select
//   pc_src_e  : PC next-value select
package tisc_pkg;

  localparam int OPC_ENC_W = 4;

  typedef enum logic [OPC_ENC_W-1:0] {
    OP_LOAD  = 4'd0,
    OP_STORE = 4'd1,
    OP_ADD   = 4'd2,
    OP_SUB   = 4'd3,
    OP_AND   = 4'd4,
    OP_OR    = 4'd5,
    OP_BEQ   = 4'd6,
    OP_JMP   = 4'd7,
    OP_HALT  = 4'd15
  } opcode_e;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3
  } alu_op_e;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JUMP   = 2'd2
  } pc_src_e;

endpackage

// File: rtl/multicycle_cu_if.sv
// multicycle_cu_if: bundle between the multi-cycle control unit and the rest
// of the core (fetch unit, data memory, ALU, register file, PC).
//   master : control unit side (drives fetch_req, pc/alu/mem/reg controls,
//            halted, illegal, retired; receives instr, instr_valid,
//            mem_ready, alu_zero)
//   slave  : core/environment side (the mirror image)
interface multicycle_cu_if #(
  parameter int INSTR_W = 16,
  parameter int CNT_W   = 16
);
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               mem_ready;
  logic               alu_zero;

  logic               fetch_req;
  logic               pc_en;
  logic [1:0]         pc_src;
  logic [2:0]         alu_op;
  logic               mem_read_en;
  logic               mem_write_en;
  logic               reg_write_en;
  logic               wb_sel;
  logic               halted;
  logic               illegal;
  logic [CNT_W-1:0]   retired;

  modport master (
    input  instr, instr_valid, mem_ready, alu_zero,
    output fetch_req, pc_en, pc_src, alu_op, mem_read_en, mem_write_en,
           reg_write_en, wb_sel, halted, illegal, retired
  );

  modport slave (
    output instr, instr_valid, mem_ready, alu_zero,
    input  fetch_req, pc_en, pc_src, alu_op, mem_read_en, mem_write_en,
           reg_write_en, wb_sel, halted, illegal, retired
  );
endinterface

// File: rtl/multicycle_cu.sv
// multicycle_cu: multi-cycle control unit for the TISC core. Steps each
// instruction through FETCH/DECODE/EXEC/MEM/WB, handshakes with instruction
// and data memory, and counts retired instructions.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : multicycle_cu_if.master (instr/instr_valid/mem_ready/alu_zero in;
//          fetch_req, pc_en, pc_src, alu_op, mem_read_en, mem_write_en,
//          reg_write_en, wb_sel, halted, illegal, retired out)
// Build option: define TISC_CU_ILLEGAL_TRAP_EN to halt on illegal opcodes and
// raise the sticky illegal flag; otherwise illegal opcodes execute as NOPs
// and illegal is tied 0.
//
// state  | meaning
// FETCH  | request instruction, wait for instr_valid
// DECODE | classify opcode, advance PC (or jump / halt)
// EXEC   | drive ALU; BEQ resolves here
// MEM    | hold data memory strobe until mem_ready
// WB     | one-cycle register-file write
// HALT   | core stopped until reset
module multicycle_cu
  import tisc_pkg::*;
#(
  parameter int INSTR_W  = 16,
  parameter int OPCODE_W = 4,
  parameter int CNT_W    = 16
) (
  input logic clk,
  input logic rst,
  multicycle_cu_if.master bus
);

  state_e              state_q, state_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic [CNT_W-1:0]    retired_q, retired_d;
  logic                retire;

  logic    fetch_req, pc_en, mem_read_en, mem_write_en, reg_write_en;
  logic    wb_sel, halted;
  pc_src_e pc_src;
  alu_op_e alu_op;

  // Only the opcode field of the instruction is used by the control unit.
  if (INSTR_W > OPCODE_W) begin : g_unused_instr
    logic unused_instr_bits;
    assign unused_instr_bits = ^bus.instr[INSTR_W-1:OPCODE_W];
  end

  logic is_load, is_store, is_add, is_sub, is_and, is_or, is_beq, is_jmp;
  logic is_halt, is_legal;

  always_comb begin
    is_load  = (op_q == OPCODE_W'(OP_LOAD));
    is_store = (op_q == OPCODE_W'(OP_STORE));
    is_add   = (op_q == OPCODE_W'(OP_ADD));
    is_sub   = (op_q == OPCODE_W'(OP_SUB));
    is_and   = (op_q == OPCODE_W'(OP_AND));
    is_or    = (op_q == OPCODE_W'(OP_OR));
    is_beq   = (op_q == OPCODE_W'(OP_BEQ));
    is_jmp   = (op_q == OPCODE_W'(OP_JMP));
    is_halt  = (op_q == OPCODE_W'(OP_HALT));
    is_legal = is_load | is_store | is_add | is_sub | is_and | is_or |
               is_beq | is_jmp | is_halt;
  end

`ifdef TISC_CU_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
`endif

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    retire       = 1'b0;
`ifdef TISC_CU_ILLEGAL_TRAP_EN
    illegal_d    = illegal_q;
`endif
    fetch_req    = 1'b0;
    pc_en        = 1'b0;
    pc_src       = PC_SEQ;
    alu_op       = ALU_ADD;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    reg_write_en = 1'b0;
    wb_sel       = 1'b0;
    halted       = 1'b0;

    unique case (state_q)
      ST_FETCH: begin
        fetch_req = 1'b1;
        if (bus.instr_valid) begin
          op_d    = bus.instr[OPCODE_W-1:0];
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: begin
        if (is_halt) begin
          state_d = ST_HALT;
        end else if (is_jmp) begin
          pc_en   = 1'b1;
          pc_src  = PC_JUMP;
          retire  = 1'b1;
          state_d = ST_FETCH;
        end else if (!is_legal) begin
`ifdef TISC_CU_ILLEGAL_TRAP_EN
          illegal_d = 1'b1;
          state_d   = ST_HALT;
`else
          pc_en   = 1'b1;
          retire  = 1'b1;
          state_d = ST_FETCH;
`endif
        end else begin
          pc_en   = 1'b1;
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        if (is_sub || is_beq) alu_op = ALU_SUB;
        else if (is_and)      alu_op = ALU_AND;
        else if (is_or)       alu_op = ALU_OR;
        else                  alu_op = ALU_ADD;

        if (is_load || is_store) begin
          state_d = ST_MEM;
        end else if (is_beq) begin
          // Branch target select is the only output looking at a live input.
          if (bus.alu_zero) begin
            pc_en  = 1'b1;
            pc_src = PC_BRANCH;
          end
          retire  = 1'b1;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_WB;
        end
      end

      ST_MEM: begin
        mem_read_en  = is_load;
        mem_write_en = !is_load;
        if (bus.mem_ready) begin
          if (is_load) begin
            state_d = ST_WB;
          end else begin
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
        end
      end

      ST_WB: begin
        reg_write_en = 1'b1;
        wb_sel       = is_load;
        retire       = 1'b1;
        state_d      = ST_FETCH;
      end

      ST_HALT: begin
        halted = 1'b1;
      end

      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  always_comb begin
    retired_d = retired_q;
    if (retire) retired_d = retired_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      op_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      retired_q <= retired_d;
    end
  end

`ifdef TISC_CU_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) illegal_q <= 1'b0;
    else     illegal_q <= illegal_d;
  end
  assign bus.illegal = illegal_q;
`else
  assign bus.illegal = 1'b0;
`endif

  assign bus.fetch_req    = fetch_req;
  assign bus.pc_en        = pc_en;
  assign bus.pc_src       = pc_src;
  assign bus.alu_op       = alu_op;
  assign bus.mem_read_en  = mem_read_en;
  assign bus.mem_write_en = mem_write_en;
  assign bus.reg_write_en = reg_write_en;
  assign bus.wb_sel       = wb_sel;
  assign bus.halted       = halted;
  assign bus.retired      = retired_q;

endmodule

// File: tb/tb_multicycle_cu.sv
// Testbench for multicycle_cu: random instruction stream with a scoreboard
// of per-instruction expectations, followed by directed reset/halt/illegal
// scenarios. Counter width is reduced so the retire counter wraps.
module tb_multicycle_cu;
  localparam int INSTR_W  = 16;
  localparam int OPCODE_W = 4;
  localparam int CNT_W    = 4;
  localparam int N_INSTR  = 150;
  localparam int BUDGET   = 20000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  multicycle_cu_if #(.INSTR_W(INSTR_W), .CNT_W(CNT_W)) bus ();

  multicycle_cu #(.INSTR_W(INSTR_W), .OPCODE_W(OPCODE_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Expected shape of one instruction, counted from its accepted FETCH cycle.
  typedef struct {
    int op;
    int cycles;
    int pc_seq;
    int pc_br;
    int pc_jmp;
    int mrd;
    int mwr;
    int rw;
    int wbsel;
    int alu;   // -1: not checked
    int ret;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t model(int op, bit z, int d, int ret_before);
    exp_t e;
    e = '{op: op, cycles: 2, pc_seq: 1, pc_br: 0, pc_jmp: 0, mrd: 0, mwr: 0,
          rw: 0, wbsel: 0, alu: -1, ret: (ret_before + 1) % (1 << CNT_W)};
    case (op)
      0: begin e.cycles = 5 + d; e.mrd = 1 + d; e.rw = 1; e.wbsel = 1; e.alu = 0; end
      1: begin e.cycles = 4 + d; e.mwr = 1 + d; e.alu = 0; end
      2, 3, 4, 5: begin e.cycles = 4; e.rw = 1; e.alu = op - 2; end
      6: begin e.cycles = 3; e.pc_br = z ? 1 : 0; e.alu = 1; end
      7: begin e.pc_seq = 0; e.pc_jmp = 1; end
      default: ;   // illegal opcode executed as NOP
    endcase
    return e;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  bit mon_en = 1'b0;
  bit m_active = 1'b0;
  int m_cyc, m_seq, m_br, m_jmp, m_bad, m_mrd, m_mwr, m_rw, m_wbsel, m_alu;
  int m_both, m_halt;

  task automatic finish_instr();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_underflow", 0, 1);
      return;
    end
    e = sb.pop_front();
    chk($sformatf("op%0d_cycles", e.op), m_cyc, e.cycles);
    chk($sformatf("op%0d_pc_seq", e.op), m_seq, e.pc_seq);
    chk($sformatf("op%0d_pc_branch", e.op), m_br, e.pc_br);
    chk($sformatf("op%0d_pc_jump", e.op), m_jmp, e.pc_jmp);
    chk($sformatf("op%0d_pc_src_bad", e.op), m_bad, 0);
    chk($sformatf("op%0d_mem_read_cycles", e.op), m_mrd, e.mrd);
    chk($sformatf("op%0d_mem_write_cycles", e.op), m_mwr, e.mwr);
    chk($sformatf("op%0d_reg_write_cycles", e.op), m_rw, e.rw);
    chk($sformatf("op%0d_wb_sel", e.op), m_wbsel, e.wbsel);
    if (e.alu >= 0) chk($sformatf("op%0d_alu_op", e.op), m_alu, e.alu);
    chk($sformatf("op%0d_strobes_both", e.op), m_both, 0);
    chk($sformatf("op%0d_halted", e.op), m_halt, 0);
    chk($sformatf("op%0d_retired", e.op), int'(bus.retired), e.ret);
  endtask

  always @(negedge clk) begin
    if (!mon_en) begin
      m_active = 1'b0;
    end else begin
      if (m_active && bus.fetch_req) begin
        finish_instr();
        m_active = 1'b0;
      end
      if (bus.fetch_req && bus.instr_valid) begin
        m_active = 1'b1;
        m_cyc = 0; m_seq = 0; m_br = 0; m_jmp = 0; m_bad = 0; m_mrd = 0;
        m_mwr = 0; m_rw = 0; m_wbsel = 0; m_alu = -1; m_both = 0; m_halt = 0;
      end
      if (m_active) begin
        m_cyc++;
        if (bus.pc_en) begin
          case (int'(bus.pc_src))
            0: m_seq++;
            1: m_br++;
            2: m_jmp++;
            default: m_bad++;
          endcase
        end
        if (bus.mem_read_en)  m_mrd++;
        if (bus.mem_write_en) m_mwr++;
        if (bus.reg_write_en) begin
          m_rw++;
          m_wbsel = int'(bus.wb_sel);
        end
        if (m_cyc == 3) m_alu = int'(bus.alu_op);
        if (bus.mem_read_en && bus.mem_write_en) m_both++;
        if (bus.halted) m_halt++;
      end
    end
  end

  // ---------------- stimulus ----------------
  int exp_ret = 0;

  function automatic int pick_op();
    int r;
    r = int'($urandom_range(0, 9));
`ifdef TISC_CU_ILLEGAL_TRAP_EN
    return r % 8;
`else
    if (r < 8) return r;
    return int'($urandom_range(8, 14));
`endif
  endfunction

  initial begin
    int issued;
    int mem_cnt;
    int cur_d;
    int op;
    bit cur_z;
    bit done;
    bit seen;
    exp_t e;

    bus.instr = '0;
    bus.instr_valid = 1'b0;
    bus.mem_ready = 1'b0;
    bus.alu_zero = 1'b0;

    // reset state
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_fetch_req", int'(bus.fetch_req), 1);
    chk("rst_pc_en", int'(bus.pc_en), 0);
    chk("rst_pc_src", int'(bus.pc_src), 0);
    chk("rst_alu_op", int'(bus.alu_op), 0);
    chk("rst_mem_read_en", int'(bus.mem_read_en), 0);
    chk("rst_mem_write_en", int'(bus.mem_write_en), 0);
    chk("rst_reg_write_en", int'(bus.reg_write_en), 0);
    chk("rst_wb_sel", int'(bus.wb_sel), 0);
    chk("rst_halted", int'(bus.halted), 0);
    chk("rst_illegal", int'(bus.illegal), 0);
    chk("rst_retired", int'(bus.retired), 0);
    @(negedge clk);
    rst = 1'b0;

    // random stream
    mon_en = 1'b1;
    issued = 0; mem_cnt = 0; cur_d = 0; cur_z = 1'b0; done = 1'b0;
    for (int cyc = 0; cyc < BUDGET; cyc++) begin
      @(posedge clk);
      #1;
      if (issued == N_INSTR && sb.size() == 0 && bus.fetch_req) begin
        done = 1'b1;
        break;
      end
      if (bus.fetch_req) begin
        if (issued < N_INSTR && $urandom_range(0, 2) != 0) begin
          op = pick_op();
          cur_d = int'($urandom_range(0, 3));
          cur_z = 1'(($urandom_range(0, 1)));
          e = model(op, cur_z, cur_d, exp_ret);
          exp_ret = e.ret;
          sb.push_back(e);
          bus.instr = (16'($urandom) & 16'hFFF0) | 16'(op);
          bus.instr_valid = 1'b1;
          bus.alu_zero = cur_z;
          mem_cnt = 0;
          issued++;
        end else begin
          bus.instr = 16'($urandom);
          bus.instr_valid = 1'b0;
          bus.alu_zero = 1'(($urandom_range(0, 1)));
        end
      end else begin
        // junk on instr/instr_valid must be ignored outside FETCH
        bus.instr = 16'($urandom);
        bus.instr_valid = 1'(($urandom_range(0, 1)));
        bus.alu_zero = cur_z;
      end
      if (bus.mem_read_en || bus.mem_write_en) begin
        bus.mem_ready = (mem_cnt >= cur_d);
        mem_cnt++;
      end else begin
        bus.mem_ready = 1'(($urandom_range(0, 1)));
      end
    end
    if (!done) chk("random_run_timeout", 0, 1);
    mon_en = 1'b0;
    bus.instr_valid = 1'b0;
    bus.mem_ready = 1'b0;

    // reset in the middle of a STORE memory access
    @(posedge clk); #1;
    bus.instr = 16'h0A01;
    bus.instr_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      bus.instr_valid = 1'b0;
      bus.mem_ready = 1'b0;
      if (bus.mem_write_en) begin
        seen = 1'b1;
        break;
      end
    end
    chk("store_reached_mem", int'(seen), 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_store_mem_write_en", int'(bus.mem_write_en), 0);
    chk("rst_mid_store_retired", int'(bus.retired), 0);
    chk("rst_mid_store_fetch_req", int'(bus.fetch_req), 1);
    @(negedge clk);
    rst = 1'b0;

    // HALT is absorbing
    @(posedge clk); #1;
    bus.instr = 16'h000F;
    bus.instr_valid = 1'b1;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      bus.instr_valid = 1'(i % 2);
      bus.instr = 16'($urandom);
      bus.mem_ready = 1'b1;
      @(negedge clk);
      chk("halt_halted", int'(bus.halted), 1);
      chk("halt_fetch_req", int'(bus.fetch_req), 0);
      chk("halt_pc_en", int'(bus.pc_en), 0);
      chk("halt_strobes", int'(bus.mem_read_en) + int'(bus.mem_write_en) + int'(bus.reg_write_en), 0);
      @(posedge clk); #1;
    end
    bus.instr_valid = 1'b0;
    bus.mem_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("halt_rst_fetch_req", int'(bus.fetch_req), 1);
    chk("halt_rst_halted", int'(bus.halted), 0);
    @(negedge clk);
    rst = 1'b0;

    // illegal opcode 0x9
    @(posedge clk); #1;
    bus.instr = 16'h0009;
    bus.instr_valid = 1'b1;
    @(negedge clk);
    chk("illegal_fetch_req", int'(bus.fetch_req), 1);
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    @(negedge clk);
`ifdef TISC_CU_ILLEGAL_TRAP_EN
    chk("illegal_decode_pc_en", int'(bus.pc_en), 0);
`else
    chk("illegal_decode_pc_en", int'(bus.pc_en), 1);
`endif
    @(posedge clk);
    @(negedge clk);
`ifdef TISC_CU_ILLEGAL_TRAP_EN
    chk("illegal_halted", int'(bus.halted), 1);
    chk("illegal_flag", int'(bus.illegal), 1);
    chk("illegal_retired", int'(bus.retired), 0);
`else
    chk("illegal_nop_fetch_req", int'(bus.fetch_req), 1);
    chk("illegal_halted", int'(bus.halted), 0);
    chk("illegal_flag", int'(bus.illegal), 0);
    chk("illegal_retired", int'(bus.retired), 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
